// File: rtl/tmul_tile_sequencer.sv
// Operand loader and result drainer for the TMUL_32_8mul8 array: serial elements -> a/b, MUL_LAT-cycle wait, 8x64b drain.
// Optional perf counters (perf_tiles, perf_stall) are built when TMUL_SEQ_PERF_EN is defined.
module tmul_tile_sequencer #(
  parameter int DW      = 32,
  parameter int N       = 8,
  parameter int MUL_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [N*DW-1:0]       mul_a,
  output logic [N*N*DW-1:0]     mul_b,
  input  logic [N*2*DW-1:0]     mul_c,
  output logic [2*DW-1:0]       m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
`ifdef TMUL_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_tiles,
  output logic [31:0]           perf_stall
`endif
);

  localparam int AW = $clog2(N);
  localparam int BW = $clog2(N*N);
  localparam int IW = BW + 1;
  localparam int LW = $clog2(MUL_LAT) + 1;
  localparam logic [IW-1:0] LAST_A  = IW'(N-1);
  localparam logic [IW-1:0] LAST_B  = IW'(N*N-1);
  localparam logic [LW-1:0] LAT_END = LW'(MUL_LAT-1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [DW-1:0]     a_q [N];
  logic [DW-1:0]     b_q [N*N];
  logic [2*DW-1:0]   res_q [N];
  logic              a_we, b_we, cap;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    busy    = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    cap     = 1'b0;
    case (state_q)
      LOAD_A: begin
        // s_ready is masked while reset is held so every output reads 0 in reset
        s_ready = rst;
        if (s_valid) begin
          a_we = 1'b1;
          if (idx_q == LAST_A) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        s_ready = rst;
        if (s_valid) begin
          b_we = 1'b1;
          if (idx_q == LAST_B) begin
            idx_d   = '0;
            lat_d   = '0;
            state_d = WAIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_q == LAT_END) begin
          cap     = 1'b1;
          lat_d   = '0;
          state_d = DRAIN;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_data  = res_q[idx_q[AW-1:0]];
        m_last  = (idx_q == LAST_A);
        if (m_ready) begin
          if (m_last) begin
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      lat_q   <= '0;
      for (int i = 0; i < N; i++) a_q[i] <= '0;
      for (int i = 0; i < N*N; i++) b_q[i] <= '0;
      for (int i = 0; i < N; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      if (a_we) a_q[idx_q[AW-1:0]] <= s_data;
      if (b_we) b_q[idx_q[BW-1:0]] <= s_data;
      if (cap) begin
        for (int m = 0; m < N; m++) res_q[m] <= mul_c[2*DW*m +: 2*DW];
      end
    end
  end

  // b element r*N+k lands at DW*(r*N+k), i.e. row r offset DW*k
  for (genvar j = 0; j < N; j++) begin : g_a
    assign mul_a[DW*j +: DW] = a_q[j];
  end
  for (genvar i = 0; i < N*N; i++) begin : g_b
    assign mul_b[DW*i +: DW] = b_q[i];
  end

`ifdef TMUL_SEQ_PERF_EN
  logic [31:0] perf_tiles_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_tiles_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (m_valid && m_ready && m_last && (perf_tiles_q != '1)) perf_tiles_q <= perf_tiles_q + 1'b1;
      if (m_valid && !m_ready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_tiles = perf_tiles_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: doc/tmul_tile_sequencer.md
Name: tmul_tile_sequencer

Overview:
- Front/back end for the TMUL_32_8mul8 array: the producer side of its a/b operand interface and the consumer side of its c result interface.
- Accepts a serial 32-bit element stream.
- Assembles operand vector a (N elements) and matrix b (N rows packed into N*DW-bit words), holds them stable on the multiplier inputs, waits the multiplier pipeline latency, captures the N 64-bit results.
- Drains the results as a 64-bit valid/ready stream.

Parameters:
- DW, 32, element width in bits.
- N, 8, vector length / matrix dimension.
- MUL_LAT, 4, clock cycles from operands stable to mul_c valid (TMUL pipeline depth).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- s_data  in  DW  input element.
- s_valid  in  1  s_data valid.
- s_ready  out  1  sequencer accepts element this cycle.
- mul_a  out  N*DW  a[j] at bits [DW*j+DW-1 : DW*j].
- mul_b  out  N*N*DW  row j at bits [N*DW*j +: N*DW]; b[j][k] at row offset [DW*k +: DW].
- mul_c  in  N*2*DW  c[m] at bits [2*DW*m +: 2*DW], from the multiplier.
- m_data  out  2*DW  result word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts.
- m_last  out  1  marks c[N-1].
- busy  out  1  high in WAIT and DRAIN.

Behaviour:
- Reset (rst low, async):
  - state = LOAD_A; element counter idx = 0; latency counter lat = 0.
  - mul_a, mul_b, result regs, m_data = 0.
  - m_valid, m_last, busy = 0; s_ready = 1 after reset release.
- Handshake: transfer occurs on a rising edge with valid&ready both high. data must be held while valid high and not ready. Valid never depends combinationally on ready.
- LOAD_A:
  - s_ready = 1.
  - Each transfer writes a[idx], idx++.
  - Transfer with idx = N-1 sets idx = 0 and moves to LOAD_B.
- LOAD_B:
  - s_ready = 1. Elements arrive row-major: element number r*N+k is written to b[r][k].
  - 7-bit counter (log2(N*N)+1). Transfer of element N*N-1 moves to WAIT with lat = 0, idx = 0.
- WAIT:
  - s_ready = 0; mul_a/mul_b held constant.
  - lat increments each cycle. In the cycle lat = MUL_LAT-1, mul_c is registered into res[0..N-1] and the state moves to DRAIN.
  - Result latency: exactly MUL_LAT cycles from the last LOAD_B transfer edge to the capture edge.
- DRAIN:
  - m_valid = 1; m_data = res[idx]; m_last = (idx == N-1).
  - Each m handshake advances idx.
  - Handshake with m_last goes to LOAD_A, idx = 0, m_valid = 0 next cycle.
  - m_ready low stalls indefinitely with outputs stable.
  - mul_a/mul_b keep the previous tile until overwritten in LOAD_A/LOAD_B.
- s_valid during WAIT/DRAIN is ignored (no transfer, s_ready = 0).
- Reset asserted mid-tile: partial tile discarded, all state as after reset. No result from that tile is emitted.
- Zero-bubble between tiles: the first LOAD_A transfer may occur in the cycle after the m_last handshake.

Optional Feature:
- Macro: TMUL_SEQ_PERF_EN.
- When defined:
  - Adds outputs perf_tiles (32 bits), incremented on each m_last handshake.
  - Adds perf_stall (32 bits), incremented each DRAIN cycle with m_valid=1 and m_ready=0.
  - Both counters are reset to 0 by rst, saturate at all-ones, and are not cleared otherwise.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then one tile, a[j]=j+1, b[j][k]=k+1, m_ready=1:
  - mul_a = {8,7,...,1} packed; mul_b row j = {8,...,1}.
  - Bench model drives mul_c[m]=64'h1000+m; capture occurs exactly MUL_LAT cycles after the 72nd transfer.
  - 8 outputs 0x1000..0x1007 are emitted back-to-back, m_last on 0x1007.
- Backpressure: m_ready toggles 1,0,0,1,...
  - m_data/m_last stable during stalls; each result emitted once, in order.
  - With TMUL_SEQ_PERF_EN, perf_stall equals the counted low-ready cycles.
- s_valid held high through WAIT/DRAIN with data 0xDEADBEEF:
  - s_ready = 0; no operand register changes; the next tile's a[0] is taken from the first element after m_last.
- rst pulsed low after 40 element transfers:
  - all outputs 0 asynchronously; a fresh 72-element tile yields correct mul_a/mul_b and exactly 8 results.
- Two tiles back-to-back (second with a[j]=j+10001, b[j][k]=k+10001):
  - second load starts the cycle after the m_last handshake.
  - With TMUL_SEQ_PERF_EN, perf_tiles = 2.
- Gaps: s_valid asserted every third cycle in LOAD_B → correct row-major packing of all 64 b elements.
